// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default widths for the game controller
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam int TICK_W_DEF  = 20;
  localparam int DEB_W_DEF   = 16;
  localparam int SCORE_W_DEF = 10;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stability counter for one button
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam logic [DEB_W-1:0] CNT_ONE = 1;

  logic             sync_a;
  logic             sync_b;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
      rise   <= 1'b0;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        // full window of disagreeing samples: accept the new level
        stable <= ~stable;
        rise   <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - game sequencer: debounce, state machine, frame tick and scoring
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_W     = TICK_W_DEF,
  parameter int DEB_W      = DEB_W_DEF,
  parameter int RST_CYC    = 4,
  parameter int LOCK_TICKS = 48,
  parameter int SCORE_W    = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         btn_raw,
  input  logic               btn_start_raw,
  input  logic               over,
  input  logic               land,
  output logic               game_rst,
  output logic               tick,
  output logic [1:0]         btn_game,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best
);

  localparam int RST_W  = $clog2(RST_CYC + 1);
  localparam int LOCK_W = $clog2(LOCK_TICKS + 1);

  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYC - 1);
  localparam logic [RST_W-1:0]   RST_ONE  = 1;
  localparam logic [LOCK_W-1:0]  LOCK_MAX = LOCK_W'(LOCK_TICKS);
  localparam logic [LOCK_W-1:0]  LOCK_ONE = 1;
  localparam logic [TICK_W-1:0]  TICK_ONE = 1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = 1;

  game_state_t        st;
  logic [TICK_W-1:0]  tick_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] best_next;
  logic [1:0]         move_stable;
  logic               start_stable;
  logic               start_pe;
  logic               unused_rise_l;
  logic               unused_rise_r;

  btn_debounce #(.DEB_W(DEB_W)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .din(btn_raw[1]), .stable(move_stable[1]), .rise(unused_rise_l)
  );

  btn_debounce #(.DEB_W(DEB_W)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .din(btn_raw[0]), .stable(move_stable[0]), .rise(unused_rise_r)
  );

  btn_debounce #(.DEB_W(DEB_W)) u_deb_start (
    .clk(clk), .rst_n(rst_n), .din(btn_start_raw), .stable(start_stable), .rise(start_pe)
  );

  // score after a possible same-cycle landing, so best sees it on game over
  assign score_inc = (land && !(&score)) ? score + SCORE_ONE : score;
  assign best_next = (score_inc > best) ? score_inc : best;
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      game_rst <= 1'b1;
      tick     <= 1'b0;
      btn_game <= 2'b00;
      score    <= '0;
      best     <= '0;
      tick_cnt <= '0;
      rst_cnt  <= '0;
      lock_cnt <= '0;
    end else begin
      tick     <= 1'b0;
      btn_game <= 2'b00;
      case (st)
        ST_IDLE: begin
          game_rst <= 1'b1;
          if (start_pe) begin
            st      <= ST_RST;
            rst_cnt <= '0;
          end
        end
        ST_RST: begin
          game_rst <= 1'b1;
          score    <= '0;
          tick_cnt <= '0;
          lock_cnt <= '0;
          if (rst_cnt == RST_LAST) begin
            st       <= ST_PLAY;
            game_rst <= 1'b0;
            btn_game <= move_stable;
          end else begin
            rst_cnt <= rst_cnt + RST_ONE;
          end
        end
        ST_PLAY: begin
          game_rst <= 1'b0;
          score    <= score_inc;
          if (over) begin
            st       <= ST_OVER;
            best     <= best_next;
            tick_cnt <= '0;
            lock_cnt <= '0;
          end else if (start_pe) begin
            st <= ST_PAUSE;
          end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
            tick     <= &tick_cnt;
            btn_game <= move_stable;
          end
        end
        ST_PAUSE: begin
          if (start_pe) begin
            st       <= ST_PLAY;
            btn_game <= move_stable;
          end
        end
        ST_OVER: begin
          // frame counter keeps running only to time the restart lockout
          tick_cnt <= tick_cnt + TICK_ONE;
          if (&tick_cnt && lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LOCK_ONE;
          if (start_pe && lock_cnt == LOCK_MAX) begin
            st       <= ST_RST;
            game_rst <= 1'b1;
            rst_cnt  <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
